fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction prefetch stage placed between instruction memory and the execute stage. It owns the fetch program counter and issues word-addressed reads to a synchronous instruction memory. It buffers returned instructions with their PCs in a small FIFO and presents them to execute through a valid/ready handshake. A redirect from execute (a taken branch or jump, whenever `nextpc != pc+1`) flushes the queue and restarts fetch at the new target.

## Interface
- `DEPTH`, 4 — FIFO entries; power of two, ≥ 4.
- `AW`, 8 — instruction memory address width in words.
- `RESET_PC`, 32'h0 — fetch PC after reset.
- `clk`  in  1  — clock; all state updates on posedge.
- `rstd`  in  1  — reset rstd, asynchronous, active-low; clock clk.
- `imem_req`  out  1  — read request this cycle.
- `imem_addr`  out  AW  — word address; equals `fpc[AW-1:0]`.
- `imem_data`  in  32  — read data; valid the cycle after the request.
- `ins`  out  32  — head instruction.
- `pc`  out  32  — PC of head instruction.
- `valid`  out  1  — head entry present.
- `ready`  in  1  — execute accepts head this cycle.
- `redirect`  in  1  — flush queue and restart fetch.
- `redirect_pc`  in  32  — new fetch PC; sampled when `redirect=1`.
- `count`  out  $clog2(DEPTH)+1  — current FIFO occupancy.

## Operation
- Internal state:
  - `fpc` (32b) — next PC to request.
  - `pend` (1b) — a response is due this cycle.
  - `pend_pc` (32b) — PC of the outstanding request.
  - FIFO of `{pc, ins}` entries, plus `count`.
- Issue rule: `imem_req = !redirect && (count + pend < DEPTH)`. On issue:
  - `pend_pc <= fpc`, `fpc <= fpc + 1` (word addressing, modulo 2^32).
  - `pend <= 1`; otherwise `pend <= 0`.
- Response: when `pend=1` and `redirect=0`, push `{pend_pc, imem_data}` at the end of the cycle. The credit rule guarantees the FIFO is never full at a push.
- Pop: on `valid && ready`, the head is removed.
- Simultaneous push and pop: `count` is unchanged; the new entry goes to the tail.
- Redirect has priority over every other action:
  - The FIFO is emptied (`count <= 0`, pointers reset).
  - `pend <= 0`; a response arriving in the redirect cycle is discarded.
  - `fpc <= redirect_pc`.
  - No request is issued in the redirect cycle.
  - A `valid && ready` transfer in the same cycle still counts as consumed by execute.
- Address wrap: `imem_addr` is the truncated low bits of `fpc`. `fpc` wraps from 32'hFFFFFFFF to 0 with no special handling.
- Stall: when `ready=0`, the FIFO fills to `DEPTH`, then `imem_req` deasserts. Fetch resumes in the cycle after the first pop frees a credit.
- `ready` while `valid=0` has no effect.

## Timing
- Reset (async, while `rstd=0`):
  - `fpc=RESET_PC`, `pend=0`, `count=0`, `valid=0`, `ins=0`, `pc=0`, `imem_req=0`.
- Reset asserted mid-operation discards all entries and the outstanding response immediately.
- Cycle 0 is the first cycle with `rstd=1`:
  - `imem_req=1` with address `RESET_PC`.
  - Data returns in cycle 1; `valid=1` with `pc=RESET_PC` in cycle 2.
- Fetch-to-valid latency is 2 cycles.
- With `ready` held at 1, throughput is 1 instruction/cycle in steady state, with `count` = 1 and `pend` = 1.
- Redirect in cycle n:
  - Request to `redirect_pc` in n+1, data in n+2.
  - `valid` with `pc=redirect_pc` in n+3.
  - `valid=0` in n+1 and n+2.
- `ins`, `pc` and `valid` are driven from registered FIFO state only; there is no combinational path from `imem_data`.
- `ready` and `redirect` affect only the next state, except `imem_req`, which depends combinationally on `redirect`.

## Structure
- Shared package holds:
  - `FQ_DEPTH` and `IMEM_AW` defaults.
  - `NOP_INS` (32'h0).
  - The `{pc, ins}` entry type as a 64-bit constant width.
- Sub-module `fq_fifo`: a DEPTH×64 register-array FIFO with push, pop, flush, `count` and head outputs, all synchronous except the async reset.
- The top level contains the fetch PC, pending tracking and credit logic.

## Test plan
- Reset release, `ready=1`, memory holds word i = 32'h1000+i:
  - `valid` rises in cycle 2 with `pc=0`, `ins=32'h1000`.
  - Then one instruction per cycle, `pc` incrementing by 1.
- `ready=0` for 10 cycles:
  - `count` saturates at 4 and `imem_req=0`.
  - After `ready=1`, entries drain in PC order 0..3 with no gap, loss or duplication.
- `redirect=1`, `redirect_pc=32'h40` while the FIFO holds 3 entries and a response is pending:
  - `count=0` and `valid=0` next cycle.
  - `valid` returns in n+3 with `pc=32'h40`.
  - No stale PC appears.
- Back-to-back redirects in cycles n and n+1 (to 32'h10 then 32'h20):
  - No entry for 32'h10 is ever presented.
  - The first valid entry has `pc=32'h20`, at n+4.
- Start with `RESET_PC=32'hFFFFFFFE`, `ready=1`:
  - PCs FFFFFFFE, FFFFFFFF, 0, 1 in order.
  - `imem_addr` is FE, FF, 00, 01.
- Assert `rstd=0` mid-stream with the FIFO full:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, the fetch sequence restarts from `RESET_PC`.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared defaults and the queue entry type for the instruction prefetch stage.
package fetch_queue_pkg;
  localparam int          FQ_DEPTH = 4;
  localparam int          IMEM_AW  = 8;
  localparam logic [31:0] NOP_INS  = 32'h0;
  localparam int          ENTRY_W  = 64;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Memory-side and execute-side signals of the prefetch stage.
// master = the fetch queue itself, slave = memory/execute environment.
interface fetch_queue_if import fetch_queue_pkg::*; #(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = IMEM_AW
);
  logic                     imem_req;
  logic [AW-1:0]            imem_addr;
  logic [31:0]              imem_data;
  logic [31:0]              ins;
  logic [31:0]              pc;
  logic                     valid;
  logic                     ready;
  logic                     redirect;
  logic [31:0]              redirect_pc;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output imem_req, imem_addr, ins, pc, valid, count,
    input  imem_data, ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, ins, pc, valid, count,
    output imem_data, ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fq_fifo.sv
// Register-array FIFO of {pc, ins} entries with synchronous flush.
// Head reads as a NOP entry whenever the FIFO is empty.
module fq_fifo import fetch_queue_pkg::*; #(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rstd,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fq_entry_t              push_data,
  output logic [$clog2(DEPTH):0] count,
  output fq_entry_t              head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t      mem [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;

  // Pointer and occupancy tracking; flush beats push and pop.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; contents need no reset because count gates the head.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '{pc: 32'h0, ins: NOP_INS};
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch: owns the fetch PC, issues one-word reads to a
// synchronous memory under a credit limit, and buffers responses for execute.
module fetch_queue import fetch_queue_pkg::*; #(
  parameter int          DEPTH    = FQ_DEPTH,
  parameter int          AW       = IMEM_AW,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk,
  input  logic          rstd,
  fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]  fpc, pend_pc;
  logic         pend, issue, push, pop;
  logic [CW-1:0] count;
  logic [CW:0]  committed;
  fq_entry_t    head, push_entry;

  // Slots already spoken for: buffered entries plus the response in flight.
  assign committed  = {1'b0, count} + (CW+1)'(pend);
  assign issue      = rstd && !bus.redirect && (committed < (CW+1)'(DEPTH));
  assign push       = pend && !bus.redirect;
  assign pop        = (count != '0) && bus.ready;
  assign push_entry = '{pc: pend_pc, ins: bus.imem_data};

  // Fetch PC and outstanding-request tracking; redirect restarts fetch.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      fpc     <= RESET_PC;
      pend    <= 1'b0;
      pend_pc <= 32'h0;
    end else if (bus.redirect) begin
      fpc  <= bus.redirect_pc;
      pend <= 1'b0;
    end else begin
      pend <= issue;
      if (issue) begin
        pend_pc <= fpc;
        fpc     <= fpc + 32'd1;
      end
    end
  end

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rstd      (rstd),
    .push      (push),
    .pop       (pop),
    .flush     (bus.redirect),
    .push_data (push_entry),
    .count     (count),
    .head      (head)
  );

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fpc[AW-1:0];
  assign bus.ins       = head.ins;
  assign bus.pc        = head.pc;
  assign bus.valid     = (count != '0);
  assign bus.count     = count;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
// A second instance starts at 32'hFFFFFFFE to exercise PC/address wrap.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          DEPTH   = 4;
  localparam int          AW      = 8;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFE;

  logic clk  = 1'b0;
  logic rstd = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH), .AW(AW)) bus ();
  fetch_queue_if #(.DEPTH(DEPTH), .AW(AW)) wbus ();

  fetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rstd(rstd), .bus(bus));
  fetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rstd(rstd), .bus(wbus));

  // Memory contents: word i holds 32'h1000 + i.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'h1000 + {{(32-AW){1'b0}}, a};
  endfunction

  // Synchronous instruction memories, one-cycle read latency.
  always @(posedge clk) if (bus.imem_req)  bus.imem_data  <= mem_word(bus.imem_addr);
  always @(posedge clk) if (wbus.imem_req) wbus.imem_data <= mem_word(wbus.imem_addr);

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model state: PCs buffered, PCs in flight, next fetch PC.
  logic [31:0] mq[$];
  logic [31:0] infl[$];
  logic [31:0] m_fpc;
  logic        m_valid, m_req;
  logic [31:0] w_pc_exp, w_addr_exp;

  // Compare mid-cycle, then advance the model with the inputs the DUT
  // is about to sample at the coming edge.
  initial forever begin
    @(negedge clk);
    if (!rstd) begin
      mq.delete();
      infl.delete();
      m_fpc      = 32'h0;
      w_pc_exp   = WRAP_PC;
      w_addr_exp = WRAP_PC;
    end else begin
      m_valid = (mq.size() != 0);
      m_req   = !bus.redirect && ((mq.size() + infl.size()) < DEPTH);
      check("valid",    64'(bus.valid),    64'(m_valid));
      check("count",    64'(bus.count),    64'(mq.size()));
      check("imem_req", 64'(bus.imem_req), 64'(m_req));
      if (m_valid) begin
        check("pc",  64'(bus.pc),  64'(mq[0]));
        check("ins", 64'(bus.ins), 64'(mem_word(mq[0][AW-1:0])));
      end
      if (m_req) check("imem_addr", 64'(bus.imem_addr), 64'(m_fpc[AW-1:0]));

      if (bus.redirect) begin
        mq.delete();
        infl.delete();
        m_fpc = bus.redirect_pc;
      end else begin
        if (m_valid && bus.ready) void'(mq.pop_front());
        if (infl.size() != 0) mq.push_back(infl.pop_front());
        if (m_req) begin
          infl.push_back(m_fpc);
          m_fpc = m_fpc + 32'd1;
        end
      end

      // Wrap instance always accepts: PCs and addresses form one
      // unbroken sequence starting at WRAP_PC.
      if (wbus.valid) begin
        check("wrap_pc",  64'(wbus.pc),  64'(w_pc_exp));
        check("wrap_ins", 64'(wbus.ins), 64'(mem_word(w_pc_exp[AW-1:0])));
        w_pc_exp = w_pc_exp + 32'd1;
      end
      if (wbus.imem_req) begin
        check("wrap_addr", 64'(wbus.imem_addr), 64'(w_addr_exp[AW-1:0]));
        w_addr_exp = w_addr_exp + 32'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ready        = 1'b1;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = 32'h0;
    wbus.ready       = 1'b1;
    wbus.redirect    = 1'b0;
    wbus.redirect_pc = 32'h0;

    // Held in reset.
    repeat (2) tick();
    check("rst_valid", 64'(bus.valid),    64'(0));
    check("rst_count", 64'(bus.count),    64'(0));
    check("rst_req",   64'(bus.imem_req), 64'(0));
    check("rst_ins",   64'(bus.ins),      64'(0));
    check("rst_pc",    64'(bus.pc),       64'(0));

    // Cycle 0 begins here.
    rstd = 1'b1;
    #1;
    check("c0_req",  64'(bus.imem_req),  64'(1));
    check("c0_addr", 64'(bus.imem_addr), 64'(0));
    tick();
    check("c1_valid", 64'(bus.valid), 64'(0));
    tick();
    check("c2_valid", 64'(bus.valid), 64'(1));
    check("c2_pc",    64'(bus.pc),    64'(0));
    check("c2_ins",   64'(bus.ins),   64'(32'h1000));
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("stream_pc",    64'(bus.pc),    64'(i));
      check("stream_valid", 64'(bus.valid), 64'(1));
    end

    // Stall with head pc=5 held; FIFO saturates.
    bus.ready = 1'b0;
    repeat (10) tick();
    check("stall_count", 64'(bus.count),    64'(4));
    check("stall_req",   64'(bus.imem_req), 64'(0));
    bus.ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("drain_pc",    64'(bus.pc),    64'(5 + k));
      check("drain_valid", 64'(bus.valid), 64'(1));
      tick();
    end

    // Redirect with three entries buffered and one response pending.
    bus.ready = 1'b0;
    for (int w = 0; w < 20 && bus.count != 3; w++) tick();
    check("wait_count3", 64'(bus.count), 64'(3));
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    bus.ready       = 1'b1;
    tick();
    bus.redirect = 1'b0;
    check("redir_n1_count", 64'(bus.count), 64'(0));
    check("redir_n1_valid", 64'(bus.valid), 64'(0));
    tick();
    check("redir_n2_valid", 64'(bus.valid), 64'(0));
    tick();
    check("redir_n3_valid", 64'(bus.valid), 64'(1));
    check("redir_n3_pc",    64'(bus.pc),    64'(32'h40));

    // Back-to-back redirects: only the second target is ever presented.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h10;
    tick();
    bus.redirect_pc = 32'h20;
    tick();
    bus.redirect = 1'b0;
    check("b2b_n2_valid", 64'(bus.valid), 64'(0));
    tick();
    check("b2b_n3_valid", 64'(bus.valid), 64'(0));
    tick();
    check("b2b_n4_valid", 64'(bus.valid), 64'(1));
    check("b2b_n4_pc",    64'(bus.pc),    64'(32'h20));

    // Randomized ready / redirect traffic, targets sometimes near the wrap.
    for (int r = 0; r < 400; r++) begin
      bus.ready    = ($urandom_range(9) < 7);
      bus.redirect = ($urandom_range(19) == 0);
      if ($urandom_range(3) == 0) bus.redirect_pc = 32'hFFFF_FFFC + 32'($urandom_range(3));
      else                        bus.redirect_pc = $urandom;
      tick();
    end
    bus.redirect = 1'b0;

    // Asynchronous reset with the FIFO full, mid-cycle.
    bus.ready = 1'b0;
    for (int w = 0; w < 20 && bus.count != 4; w++) tick();
    check("pre_rst_count", 64'(bus.count), 64'(4));
    #2;
    rstd = 1'b0;
    #1;
    check("arst_valid", 64'(bus.valid),    64'(0));
    check("arst_count", 64'(bus.count),    64'(0));
    check("arst_req",   64'(bus.imem_req), 64'(0));
    check("arst_pc",    64'(bus.pc),       64'(0));
    check("arst_ins",   64'(bus.ins),      64'(0));
    check("arst_wrap_valid", 64'(wbus.valid), 64'(0));
    tick();
    tick();
    bus.ready = 1'b1;
    rstd = 1'b1;
    #1;
    check("rst2_c0_req",  64'(bus.imem_req),  64'(1));
    check("rst2_c0_addr", 64'(bus.imem_addr), 64'(0));
    tick();
    tick();
    check("rst2_c2_valid", 64'(bus.valid), 64'(1));
    check("rst2_c2_pc",    64'(bus.pc),    64'(0));
    check("rst2_c2_ins",   64'(bus.ins),   64'(32'h1000));
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
